// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the 8x8 single-channel CNN layer sequencer.
package cnn_pkg;

    localparam int IMG_W         = 8;
    localparam int IMG_H         = 8;
    localparam int K             = 3;
    localparam int NUM_FILT      = 2;
    localparam int OUT_W         = IMG_W - K + 1;
    localparam int OUT_H         = IMG_H - K + 1;
    localparam int TAPS_PER_FILT = K * K;
    localparam int N_PIX         = IMG_W * IMG_H;
    localparam int N_TAPS        = TAPS_PER_FILT * NUM_FILT;
    localparam int N_POS         = OUT_W * OUT_H;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        EMIT,
        DONE
    } state_t;

    function automatic logic [5:0] out_pos_of(input logic [2:0] ox, input logic [2:0] oy);
        return 6'(oy) * 6'(OUT_W) + 6'(ox);
    endfunction

endpackage

// File: rtl/cnn_tap_addr_gen.sv
// Maps (output column, output row, sweep tap) to image/weight read addresses and filter select.
module cnn_tap_addr_gen
    import cnn_pkg::*;
(
    input  logic [2:0] i_ox,
    input  logic [2:0] i_oy,
    input  logic [4:0] i_t,
    output logic [5:0] o_img_rd_addr,
    output logic [4:0] o_w_rd_addr,
    output logic       o_filt_sel
);

    logic       w_filt;
    logic [3:0] w_tap;
    logic [2:0] w_ky;
    logic [2:0] w_kx;
    logic [2:0] w_row;
    logic [2:0] w_col;

    // The sweep covers filter 0 taps first, then filter 1 taps at the same window.
    assign w_filt = (i_t >= 5'(TAPS_PER_FILT));
    assign w_tap  = w_filt ? 4'(i_t - 5'(TAPS_PER_FILT)) : 4'(i_t);
    assign w_ky   = 3'(w_tap / 4'(K));
    assign w_kx   = 3'(w_tap % 4'(K));
    assign w_row  = i_oy + w_ky;
    assign w_col  = i_ox + w_kx;

    assign o_img_rd_addr = 6'(w_row) * 6'(IMG_W) + 6'(w_col);
    assign o_w_rd_addr   = i_t;
    assign o_filt_sel    = w_filt;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame controller for the shared conv MAC: loads pixels, sweeps taps per output
// position for both filters, and presents each result under valid/ready.
//
// state   | meaning
// IDLE    | waiting for start, all strobes low
// LOAD    | writing incoming pixels 0..63 into the image buffer
// COMPUTE | one kernel tap per cycle, t = 0..17 across both filters
// EMIT    | result valid, held until downstream accepts
// DONE    | one-cycle frame-complete pulse
module cnn_layer_sequencer
    import cnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_pix_valid,
    output logic       o_pix_wr_en,
    output logic [5:0] o_pix_wr_addr,
    output logic [5:0] o_img_rd_addr,
    output logic [4:0] o_w_rd_addr,
    output logic       o_filt_sel,
    output logic       o_acc_clr,
    output logic       o_mac_en,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [5:0] o_out_pos,
    output logic       o_busy,
    output logic       o_done
);

    state_t     r_state;
    logic [6:0] r_p;
    logic [4:0] r_t;
    logic [2:0] r_ox;
    logic [2:0] r_oy;

    state_t     w_nxt_state;
    logic [6:0] w_nxt_p;
    logic [4:0] w_nxt_t;
    logic [2:0] w_nxt_ox;
    logic [2:0] w_nxt_oy;
    logic       w_nxt_pix_wr_en;
    logic [5:0] w_nxt_pix_wr_addr;
    logic       w_last_pos;
    logic       w_last_pix;

    logic [5:0] w_img_rd_addr;
    logic [4:0] w_w_rd_addr;
    logic       w_filt_sel;

    assign w_last_pos = (r_ox == 3'(OUT_W - 1)) && (r_oy == 3'(OUT_H - 1));
    assign w_last_pix = o_pix_wr_en && (o_pix_wr_addr == 6'(N_PIX - 1));

    // Addresses are generated from the next-cycle counters so they land in registers.
    cnn_tap_addr_gen u_tap_addr_gen (
        .i_ox          (w_nxt_ox),
        .i_oy          (w_nxt_oy),
        .i_t           (w_nxt_t),
        .o_img_rd_addr (w_img_rd_addr),
        .o_w_rd_addr   (w_w_rd_addr),
        .o_filt_sel    (w_filt_sel)
    );

    always_comb begin
        w_nxt_state       = r_state;
        w_nxt_p           = r_p;
        w_nxt_t           = r_t;
        w_nxt_ox          = r_ox;
        w_nxt_oy          = r_oy;
        w_nxt_pix_wr_en   = 1'b0;
        w_nxt_pix_wr_addr = o_pix_wr_addr;

        case (r_state)
            IDLE: begin
                w_nxt_pix_wr_addr = '0;
                if (i_start) begin
                    w_nxt_state = LOAD;
                    w_nxt_p     = '0;
                end
            end

            LOAD: begin
                // Leave only once the final write has been presented to the buffer.
                if (w_last_pix) begin
                    w_nxt_state = COMPUTE;
                    w_nxt_t     = '0;
                    w_nxt_ox    = '0;
                    w_nxt_oy    = '0;
                end else if (i_pix_valid) begin
                    w_nxt_pix_wr_en   = 1'b1;
                    w_nxt_pix_wr_addr = r_p[5:0];
                    w_nxt_p           = r_p + 7'd1;
                end
            end

            COMPUTE: begin
                if (r_t == 5'(N_TAPS - 1)) begin
                    w_nxt_state = EMIT;
                end else begin
                    w_nxt_t = r_t + 5'd1;
                end
            end

            EMIT: begin
                if (o_out_valid && i_out_ready) begin
                    if (w_last_pos) begin
                        w_nxt_state = DONE;
                    end else begin
                        w_nxt_state = COMPUTE;
                        w_nxt_t     = '0;
                        if (r_ox == 3'(OUT_W - 1)) begin
                            w_nxt_ox = '0;
                            w_nxt_oy = r_oy + 3'd1;
                        end else begin
                            w_nxt_ox = r_ox + 3'd1;
                        end
                    end
                end
            end

            DONE: begin
                w_nxt_state = IDLE;
                w_nxt_p     = '0;
                w_nxt_t     = '0;
                w_nxt_ox    = '0;
                w_nxt_oy    = '0;
            end

            default: begin
                w_nxt_state = IDLE;
            end
        endcase

        if (i_abort) begin
            w_nxt_state       = IDLE;
            w_nxt_p           = '0;
            w_nxt_t           = '0;
            w_nxt_ox          = '0;
            w_nxt_oy          = '0;
            w_nxt_pix_wr_en   = 1'b0;
            w_nxt_pix_wr_addr = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_p           <= '0;
            r_t           <= '0;
            r_ox          <= '0;
            r_oy          <= '0;
            o_pix_wr_en   <= 1'b0;
            o_pix_wr_addr <= '0;
            o_img_rd_addr <= '0;
            o_w_rd_addr   <= '0;
            o_filt_sel    <= 1'b0;
            o_acc_clr     <= 1'b0;
            o_mac_en      <= 1'b0;
            o_out_valid   <= 1'b0;
            o_out_pos     <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_p           <= w_nxt_p;
            r_t           <= w_nxt_t;
            r_ox          <= w_nxt_ox;
            r_oy          <= w_nxt_oy;
            o_pix_wr_en   <= w_nxt_pix_wr_en;
            o_pix_wr_addr <= w_nxt_pix_wr_addr;
            o_img_rd_addr <= (w_nxt_state == COMPUTE) ? w_img_rd_addr : '0;
            o_w_rd_addr   <= (w_nxt_state == COMPUTE) ? w_w_rd_addr : '0;
            o_filt_sel    <= (w_nxt_state == COMPUTE) && w_filt_sel;
            o_acc_clr     <= (w_nxt_state == COMPUTE) && (w_nxt_t == '0);
            o_mac_en      <= (w_nxt_state == COMPUTE);
            o_out_valid   <= (w_nxt_state == EMIT);
            o_out_pos     <= ((w_nxt_state == COMPUTE) || (w_nxt_state == EMIT))
                             ? out_pos_of(w_nxt_ox, w_nxt_oy) : '0;
            o_busy        <= (w_nxt_state != IDLE);
            o_done        <= (w_nxt_state == DONE);
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: load, tap addressing, backpressure, full frame, abort, reset.
module tb_cnn_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic       i_abort;
    logic       i_pix_valid;
    logic       o_pix_wr_en;
    logic [5:0] o_pix_wr_addr;
    logic [5:0] o_img_rd_addr;
    logic [4:0] o_w_rd_addr;
    logic       o_filt_sel;
    logic       o_acc_clr;
    logic       o_mac_en;
    logic       o_out_valid;
    logic       i_out_ready;
    logic [5:0] o_out_pos;
    logic       o_busy;
    logic       o_done;

    logic [29:0] w_all;
    assign w_all = {o_pix_wr_en, o_pix_wr_addr, o_img_rd_addr, o_w_rd_addr, o_filt_sel,
                    o_acc_clr, o_mac_en, o_out_valid, o_out_pos, o_busy, o_done};

    int n_cmp = 0;
    int n_err = 0;
    int q_exp[$];

    cnn_layer_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_pix_valid   (i_pix_valid),
        .o_pix_wr_en   (o_pix_wr_en),
        .o_pix_wr_addr (o_pix_wr_addr),
        .o_img_rd_addr (o_img_rd_addr),
        .o_w_rd_addr   (o_w_rd_addr),
        .o_filt_sel    (o_filt_sel),
        .o_acc_clr     (o_acc_clr),
        .o_mac_en      (o_mac_en),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_pos     (o_out_pos),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i_start = 1'b0; i_abort = 1'b0; i_pix_valid = 1'b0; i_out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start_and_load();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_pix_valid = 1'b1;
        repeat (64) tick();
        i_pix_valid = 1'b0;
    endtask

    task automatic wait_emit_pos(input int pos, output bit found);
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            tick();
            if (o_out_valid === 1'b1 && o_out_pos === 6'(pos)) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        i_start = 1'b0; i_abort = 1'b0; i_pix_valid = 1'b0; i_out_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        n_cmp++;
        if (w_all !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", w_all);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_load_first_compute();
        int exp;
        logic [13:0] got;
        i_out_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b1) begin
            n_err++; $display("FAIL load_busy: got %b expected 1", o_busy);
        end
        for (int i = 0; i < 64; i++) begin
            i_pix_valid = 1'b1;
            q_exp.push_back(i);
            tick();
            n_cmp++;
            if (o_pix_wr_en !== 1'b1) begin
                n_err++; $display("FAIL load_wr_en[%0d]: got %b expected 1", i, o_pix_wr_en);
            end else begin
                exp = q_exp.pop_front();
                if (o_pix_wr_addr !== 6'(exp)) begin
                    n_err++; $display("FAIL load_wr_addr: got %0d expected %0d", o_pix_wr_addr, exp);
                end
            end
        end
        q_exp.delete();
        i_pix_valid = 1'b0;
        tick();
        got = {o_pix_wr_en, o_img_rd_addr, o_w_rd_addr, o_acc_clr, o_mac_en};
        n_cmp++;
        if (got !== {1'b0, 6'd0, 5'd0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL first_compute: got wr_en=%b img=%0d w=%0d clr=%b mac=%b expected 0/0/0/1/1",
                              o_pix_wr_en, o_img_rd_addr, o_w_rd_addr, o_acc_clr, o_mac_en);
        end
        apply_reset();
    endtask

    task automatic test_tap_addr();
        i_out_ready = 1'b1;
        start_and_load();
        repeat (1 + 19 * 17) tick();
        n_cmp++;
        if (o_acc_clr !== 1'b1 || o_img_rd_addr !== 6'd21 || o_out_pos !== 6'd17) begin
            n_err++; $display("FAIL tap_pos17_t0: got clr=%b img=%0d pos=%0d expected 1/21/17",
                              o_acc_clr, o_img_rd_addr, o_out_pos);
        end
        repeat (8) tick();
        n_cmp++;
        if (o_img_rd_addr !== 6'd39 || o_w_rd_addr !== 5'd8 || o_filt_sel !== 1'b0 ||
            o_acc_clr !== 1'b0 || o_mac_en !== 1'b1) begin
            n_err++; $display("FAIL tap_t8: got img=%0d w=%0d filt=%b clr=%b mac=%b expected 39/8/0/0/1",
                              o_img_rd_addr, o_w_rd_addr, o_filt_sel, o_acc_clr, o_mac_en);
        end
        tick();
        n_cmp++;
        if (o_img_rd_addr !== 6'd21 || o_w_rd_addr !== 5'd9 || o_filt_sel !== 1'b1 || o_acc_clr !== 1'b0) begin
            n_err++; $display("FAIL tap_t9: got img=%0d w=%0d filt=%b clr=%b expected 21/9/1/0",
                              o_img_rd_addr, o_w_rd_addr, o_filt_sel, o_acc_clr);
        end
        apply_reset();
    endtask

    task automatic test_backpressure();
        bit found;
        i_out_ready = 1'b1;
        start_and_load();
        wait_emit_pos(7, found);
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL bp_reach_pos7: got timeout expected out_valid at pos 7");
        end
        i_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (o_out_valid !== 1'b1 || o_out_pos !== 6'd7 || o_mac_en !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: got valid=%b pos=%0d mac=%b expected 1/7/0",
                                  i, o_out_valid, o_out_pos, o_mac_en);
            end
        end
        i_out_ready = 1'b1;
        tick();
        n_cmp++;
        if (o_out_valid !== 1'b0 || o_out_pos !== 6'd8 || o_acc_clr !== 1'b1 ||
            o_mac_en !== 1'b1 || o_img_rd_addr !== 6'd10) begin
            n_err++; $display("FAIL bp_release: got valid=%b pos=%0d clr=%b mac=%b img=%0d expected 0/8/1/1/10",
                              o_out_valid, o_out_pos, o_acc_clr, o_mac_en, o_img_rd_addr);
        end
        apply_reset();
    endtask

    task automatic test_full_frame();
        int c, first_v, hs, n_done, done_c, exp;
        localparam int FIRST_VALID_EDGE = 64 + 18 + 1;
        localparam int DONE_EDGE        = 1 + 64 + 36 * 19 + 1 - 1;
        first_v = -1; hs = 0; n_done = 0; done_c = -1;
        for (int p = 0; p < 36; p++) q_exp.push_back(p);
        i_out_ready = 1'b1;
        i_start = 1'b1;
        tick();
        c = 0;
        i_start = 1'b0;
        i_pix_valid = 1'b1;
        repeat (64) begin tick(); c++; end
        i_pix_valid = 1'b0;
        for (int i = 0; i < 900; i++) begin
            tick(); c++;
            if (o_out_valid === 1'b1) begin
                if (first_v < 0) first_v = c;
                hs++;
                n_cmp++;
                if (q_exp.size() == 0) begin
                    n_err++; $display("FAIL frame_extra_result: got pos=%0d expected none", o_out_pos);
                end else begin
                    exp = q_exp.pop_front();
                    if (o_out_pos !== 6'(exp)) begin
                        n_err++; $display("FAIL frame_out_pos: got %0d expected %0d", o_out_pos, exp);
                    end
                end
            end
            if (o_done === 1'b1) begin n_done++; done_c = c; end
            if (n_done > 0 && c >= done_c + 2) break;
        end
        n_cmp++;
        if (first_v != FIRST_VALID_EDGE) begin
            n_err++; $display("FAIL frame_first_valid: got %0d expected %0d", first_v, FIRST_VALID_EDGE);
        end
        n_cmp++;
        if (hs != 36 || q_exp.size() != 0) begin
            n_err++; $display("FAIL frame_handshakes: got %0d expected 36", hs);
        end
        n_cmp++;
        if (n_done != 1 || done_c != DONE_EDGE) begin
            n_err++; $display("FAIL frame_done: got count=%0d edge=%0d expected 1/%0d", n_done, done_c, DONE_EDGE);
        end
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_err++; $display("FAIL frame_busy_after: got %b expected 0", o_busy);
        end
        q_exp.delete();
        apply_reset();
    endtask

    task automatic test_abort_and_stall();
        bit found;
        int n_done;
        i_out_ready = 1'b1;
        start_and_load();
        wait_emit_pos(12, found);
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL abort_reach_pos12: got timeout expected out_valid at pos 12");
        end
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        n_cmp++;
        if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_mac_en !== 1'b0 || o_acc_clr !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: got valid=%b busy=%b mac=%b clr=%b expected 0/0/0/0",
                              o_out_valid, o_busy, o_mac_en, o_acc_clr);
        end
        n_done = 0;
        repeat (30) begin tick(); if (o_done === 1'b1) n_done++; end
        n_cmp++;
        if (n_done != 0 || o_busy !== 1'b0) begin
            n_err++; $display("FAIL abort_no_done: got done=%0d busy=%b expected 0/0", n_done, o_busy);
        end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (o_pix_wr_en !== 1'b0 || o_busy !== 1'b1) begin
                n_err++; $display("FAIL stall[%0d]: got wr_en=%b busy=%b expected 0/1", i, o_pix_wr_en, o_busy);
            end
        end
        i_pix_valid = 1'b1;
        tick();
        i_pix_valid = 1'b0;
        n_cmp++;
        if (o_pix_wr_en !== 1'b1 || o_pix_wr_addr !== 6'd0) begin
            n_err++; $display("FAIL stall_resume: got wr_en=%b addr=%0d expected 1/0", o_pix_wr_en, o_pix_wr_addr);
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_load();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_pix_valid = 1'b1;
        repeat (20) tick();
        i_pix_valid = 1'b0;
        n_cmp++;
        if (o_pix_wr_addr !== 6'd19) begin
            n_err++; $display("FAIL midload_addr: got %0d expected 19", o_pix_wr_addr);
        end
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (w_all !== '0) begin
            n_err++; $display("FAIL midload_async_reset: got %h expected 0", w_all);
        end
        tick();
        rst_n = 1'b1;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_pix_valid = 1'b1;
        tick();
        i_pix_valid = 1'b0;
        n_cmp++;
        if (o_pix_wr_en !== 1'b1 || o_pix_wr_addr !== 6'd0) begin
            n_err++; $display("FAIL midload_restart: got wr_en=%b addr=%0d expected 1/0", o_pix_wr_en, o_pix_wr_addr);
        end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_load_first_compute();
        test_tap_addr();
        test_backpressure();
        test_full_frame();
        test_abort_and_stall();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
